// File: rtl/exec_control_if.sv
// Control-panel / processor handshake bundle for the execution controller.
interface exec_control_if #(
    parameter int unsigned PC_W  = 5,
    parameter int unsigned CNT_W = 16
);
    logic             step_key;
    logic             run_sw;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             overflow;
    logic             cpu_en;
    logic             halted;
    logic [1:0]       state;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] instr_count;

    // Board/processor side: drives keys, switches and processor status.
    modport master (
        output step_key, run_sw, bp_en, bp_addr, pc, overflow,
        input  cpu_en, halted, state, halt_cause, instr_count
    );

    // Controller side.
    modport slave (
        input  step_key, run_sw, bp_en, bp_addr, pc, overflow,
        output cpu_en, halted, state, halt_cause, instr_count
    );
endinterface

// File: rtl/exec_control.sv
// Execution controller: issues one-cycle commit pulses to the single-cycle
// processor from a debounced step key or a divided free-run, with PC
// breakpoint, halt-on-overflow and a retired-instruction counter.
module exec_control #(
    parameter int unsigned PC_W            = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic          clock,
    input  logic          reset,
    exec_control_if.slave bus
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    logic            step_s1_q, step_s1_d, step_s2_q, step_s2_d;
    logic            run_s1_q, run_s1_d, run_s2_q, run_s2_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d, db_prev_q, db_prev_d;
    logic            step_pulse_q, step_pulse_d;

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             skip_bp_q, skip_bp_d;
    logic             cpu_en_q, cpu_en_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_c;
    logic             bp_hit_c;

    assign pc_c     = bus.pc;
    assign bp_hit_c = bus.bp_en && (pc_c == bus.bp_addr) && !skip_bp_q;

    // Synchronizers, step-key stability counter and rising-edge detect.
    always_comb begin
        step_s1_d    = bus.step_key;
        step_s2_d    = step_s1_q;
        run_s1_d     = bus.run_sw;
        run_s2_d     = run_s1_q;
        db_level_d   = db_level_q;
        db_cnt_d     = '0;
        db_prev_d    = db_level_q;
        step_pulse_d = db_level_q & ~db_prev_q;
        if (step_s2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = step_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Mode FSM, run divider, breakpoint and overflow handling.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        div_d     = div_q;
        skip_bp_d = skip_bp_q;
        cpu_en_d  = 1'b0;
        count_d   = count_q + CNT_W'(cpu_en_q);

        case (state_q)
            ST_IDLE: begin
                if (run_s2_q) begin
                    state_d   = ST_RUN;
                    div_d     = '0;
                    skip_bp_d = 1'b1;
                end else if (step_pulse_q) begin
                    cpu_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!run_s2_q) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
                    div_d = '0;
                    if (bp_hit_c) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_BP;
                    end else begin
                        cpu_en_d  = 1'b1;
                        skip_bp_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HALT: begin
                if (!run_s2_q) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An overflowing committed instruction wins over everything else.
        if (cpu_en_q && bus.overflow) begin
            state_d  = ST_HALT;
            cause_d  = CAUSE_OVF;
            cpu_en_d = 1'b0;
        end

        halted_d = (state_d == ST_HALT);
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_s1_q    <= 1'b0;
            step_s2_q    <= 1'b0;
            run_s1_q     <= 1'b0;
            run_s2_q     <= 1'b0;
            db_cnt_q     <= '0;
            db_level_q   <= 1'b0;
            db_prev_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            state_q      <= ST_IDLE;
            cause_q      <= CAUSE_NONE;
            div_q        <= '0;
            skip_bp_q    <= 1'b0;
            cpu_en_q     <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            step_s1_q    <= step_s1_d;
            step_s2_q    <= step_s2_d;
            run_s1_q     <= run_s1_d;
            run_s2_q     <= run_s2_d;
            db_cnt_q     <= db_cnt_d;
            db_level_q   <= db_level_d;
            db_prev_q    <= db_prev_d;
            step_pulse_q <= step_pulse_d;
            state_q      <= state_d;
            cause_q      <= cause_d;
            div_q        <= div_d;
            skip_bp_q    <= skip_bp_d;
            cpu_en_q     <= cpu_en_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
        end
    end

    assign bus.cpu_en      = cpu_en_q;
    assign bus.halted      = halted_q;
    assign bus.state       = state_q;
    assign bus.halt_cause  = cause_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_exec_control.sv
// Directed bench for exec_control with a PC-incrementing processor model.
module tb_exec_control;
    localparam int unsigned PC_W  = 5;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEB   = 4;
    localparam int unsigned DIV   = 4;

    logic clock = 1'b0;
    logic reset;
    logic ovf_arm;
    logic [PC_W-1:0] pc_m;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    int unsigned cyc = 0;
    int unsigned pulses = 0;
    int unsigned back2back = 0;
    int unsigned en_in_halt = 0;
    int unsigned pulse_cyc[$];
    logic prev_en = 1'b0;

    always #5 clock = ~clock;

    exec_control_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    exec_control #(
        .PC_W(PC_W), .DEBOUNCE_CYCLES(DEB), .RUN_DIV(DIV), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Processor model: PC advances on every commit pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_m <= '0;
        else if (bus.cpu_en) pc_m <= pc_m + PC_W'(1);
    end
    assign bus.pc       = pc_m;
    assign bus.overflow = ovf_arm & (pc_m == PC_W'(1));

    // Pulse monitor sampled on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            prev_en = 1'b0;
        end else begin
            if (bus.cpu_en) begin
                pulses++;
                pulse_cyc.push_back(cyc);
                if (prev_en) back2back++;
                if (bus.state == 2'b11) en_in_halt++;
            end
            prev_en = bus.cpu_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.run_sw   = 1'b0;
        bus.step_key = 1'b0;
        bus.bp_en    = 1'b0;
        ovf_arm      = 1'b0;
        reset        = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        int unsigned p0, base, entry, elapsed, bad;
        bus.step_key = 1'b0;
        bus.run_sw   = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        ovf_arm      = 1'b0;
        reset        = 1'b1;
        tick(2);

        // Reset values
        chk("rst_cpu_en", 32'(bus.cpu_en), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_cause", 32'(bus.halt_cause), 0);
        chk("rst_count", 32'(bus.instr_count), 0);

        // 1: asynchronous reset in RUN during the 8th pulse (count already 7)
        do_reset();
        bus.run_sw = 1'b1;
        for (int i = 0; i < 80 && !(bus.instr_count == CNT_W'(7) && bus.cpu_en); i++) tick();
        chk("t1_reach", 32'(bus.instr_count == CNT_W'(7) && bus.cpu_en), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t1_cpu_en", 32'(bus.cpu_en), 0);
        chk("t1_state", 32'(bus.state), 0);
        chk("t1_count", 32'(bus.instr_count), 0);
        bus.run_sw = 1'b0;
        tick(2);

        // 2: debounce, three short bounces then a long hold
        do_reset();
        p0 = pulses;
        for (int b = 0; b < 3; b++) begin
            bus.step_key = 1'b1; tick(2);
            bus.step_key = 1'b0; tick(2);
        end
        bus.step_key = 1'b1; tick(20);
        chk("t2_pulses1", pulses - p0, 1);
        chk("t2_count1", 32'(bus.instr_count), 1);
        bus.step_key = 1'b0; tick(12);
        bus.step_key = 1'b1; tick(20);
        bus.step_key = 1'b0; tick(12);
        chk("t2_pulses2", pulses - p0, 2);
        chk("t2_count2", 32'(bus.instr_count), 2);

        // 3: free run for 24 cycles; RUN occupies edges 3..26, attempts every 4th
        do_reset();
        base = pulse_cyc.size();
        bus.run_sw = 1'b1;
        elapsed = 0;
        for (int i = 0; i < 10 && bus.state != 2'b10; i++) begin
            tick(); elapsed++;
        end
        entry = cyc;
        chk("t3_entry", 32'(bus.state), 2);
        tick(24 - elapsed);
        bus.run_sw = 1'b0;
        tick(20);
        chk("t3_pulses", pulse_cyc.size() - base, (26 - 3) / DIV);
        chk("t3_count", 32'(bus.instr_count), (26 - 3) / DIV);
        chk("t3_state", 32'(bus.state), 0);
        if (pulse_cyc.size() > base) chk("t3_first", pulse_cyc[base] - entry, DIV);
        bad = 0;
        for (int i = base + 1; i < pulse_cyc.size(); i++)
            if (pulse_cyc[i] - pulse_cyc[i-1] != DIV) bad++;
        chk("t3_gap", bad, 0);

        // 4: breakpoint at 3, then resume through it
        do_reset();
        bus.bp_en   = 1'b1;
        bus.bp_addr = PC_W'(3);
        bus.run_sw  = 1'b1;
        for (int i = 0; i < 60 && !bus.halted; i++) tick();
        chk("t4_halted", 32'(bus.halted), 1);
        chk("t4_state", 32'(bus.state), 3);
        chk("t4_cause", 32'(bus.halt_cause), 1);
        chk("t4_count", 32'(bus.instr_count), 3);
        chk("t4_pc", 32'(pc_m), 3);
        bus.run_sw = 1'b0; tick(6);
        chk("t4_idle", 32'(bus.state), 0);
        chk("t4_cause_clr", 32'(bus.halt_cause), 0);
        bus.run_sw = 1'b1;
        for (int i = 0; i < 60 && pc_m < PC_W'(5); i++) tick();
        chk("t4_past", 32'(pc_m), 5);
        chk("t4_run", 32'(bus.state), 2);
        bus.run_sw = 1'b0;
        tick(6);

        // 5: overflow on the 2nd run pulse, then a step press while halted
        do_reset();
        ovf_arm = 1'b1;
        bus.run_sw = 1'b1;
        for (int i = 0; i < 60 && !bus.halted; i++) tick();
        chk("t5_state", 32'(bus.state), 3);
        chk("t5_cause", 32'(bus.halt_cause), 2);
        chk("t5_count", 32'(bus.instr_count), 2);
        p0 = pulses;
        tick(20);
        bus.step_key = 1'b1; tick(20);
        bus.step_key = 1'b0; tick(12);
        chk("t5_nopulse", pulses - p0, 0);
        chk("t5_still", 32'(bus.halted), 1);
        ovf_arm = 1'b0;

        // 6: counter wrap across 16 run pulses
        do_reset();
        p0 = pulses;
        bus.run_sw = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            for (int i = 0; i < 12 && pulses - p0 < k; i++) tick();
            tick();
            chk($sformatf("t6_cnt%0d", k), 32'(bus.instr_count), k % 16);
        end
        chk("t6_state", 32'(bus.state), 2);
        chk("t6_cause", 32'(bus.halt_cause), 0);
        bus.run_sw = 1'b0;
        tick(6);

        chk("b2b", back2back, 0);
        chk("en_in_halt", en_in_halt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
